fft_input_scheduler: RTL and testbench

FFT_INPUT_SCHEDULER -- requirements
Module: fft_input_scheduler

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_rr_arbiter.sv | 36 +++
 rtl/fft_input_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fft_input_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT input scheduler and its arbiter.
//   NREQ  - number of requesters sharing the FFT input RAM
//   PTR_W - width of the round-robin pointer (index of the next preferred requester)
//   state_e - scheduler FSM state encoding
package fft_pkg;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned PTR_W = 1;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLoad      = 3'd1,
        StTrig      = 3'd2,
        StWaitStart = 3'd3,
        StWaitEnd   = 3'd4,
        StRelease   = 3'd5
    } state_e;

endpackage

// File: rtl/fft_rr_arbiter.sv
// fft_rr_arbiter: combinational round-robin arbiter.
//   en_i   - arbitration enable; grant is zero when low
//   req_i  - request vector
//   ptr_i  - requester with highest priority this round
//   gnt_o  - one-hot grant, or zero when no request / disabled
//   ptr_o  - pointer to load if gnt_o is taken (requester after the winner)
module fft_rr_arbiter
    import fft_pkg::*;
(
    input  logic             en_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan from ptr_i upward; NREQ is a power of two so the index wraps for free.
    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr_i + PTR_W'(i);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_o      = idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_input_scheduler.sv
// fft_input_scheduler: shares one FFT input RAM between two requesters.
// A requester is granted, loads its frame through the muxed RAM write port,
// signals done, and the scheduler then triggers the stream and waits for it
// to start and finish before acking the requester.
//   clk, reset          - clock, synchronous active-high reset
//   req, done           - per-requester frame request (level) and loaded pulse
//   req_waddr/wdata/wen - packed per-requester write ports
//   gnt, ack            - one-hot grant, end-of-frame pulse
//   ram_waddr/wdata/wen - muxed write port to the FFT input block
//   trig, streaming     - stream trigger out, stream-active flag in
//   busy, frame_cnt     - not-idle flag, completed frame counter (wrapping)
//   err                 - sticky watchdog error
// Optional feature: define FFT_SCHED_WATCHDOG_EN to abort a frame that spends
// TIMEOUT cycles waiting on the stream; otherwise err is tied low.
module fft_input_scheduler
    import fft_pkg::*;
#(
    parameter  int unsigned NFFT    = 8,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned AW      = $clog2(2 * NFFT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      done,
    input  logic [NREQ*AW-1:0]   req_waddr,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_wen,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [AW-1:0]        ram_waddr,
    output logic [31:0]          ram_wdata,
    output logic                 ram_wen,
    output logic                 trig,
    input  logic                 streaming,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 err
);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [PTR_W-1:0] arb_ptr;
    logic [PTR_W-1:0] g_idx;
    logic [AW-1:0]    waddr_a [NREQ];
    logic [31:0]      wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign waddr_a[i] = req_waddr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*32 +: 32];
    end

    fft_rr_arbiter u_arb (
        .en_i  (state_q == StIdle),
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .ptr_o (arb_ptr)
    );

    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) g_idx = PTR_W'(i);
        end
    end

    // Write port follows the granted requester with no added latency.
    assign ram_waddr = waddr_a[g_idx];
    assign ram_wdata = wdata_a[g_idx];
    assign ram_wen   = (state_q == StLoad) && req_wen[g_idx];

`ifdef FFT_SCHED_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                // Pointer advances at grant time, so aborted frames still rotate.
                if (|req) begin
                    gnt_d   = arb_gnt;
                    ptr_d   = arb_ptr;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (!req[g_idx]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (done[g_idx]) begin
                    state_d = StTrig;
                end
            end
            StTrig:      state_d = StWaitStart;
            StWaitStart: if (streaming) state_d = StWaitEnd;
            StWaitEnd:   if (!streaming) state_d = StRelease;
            StRelease: begin
                state_d     = StIdle;
                gnt_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

`ifdef FFT_SCHED_WATCHDOG_EN
        wd_cnt_d = '0;
        err_d    = err_q;
        if (state_q == StWaitStart || state_q == StWaitEnd) begin
            if (wd_cnt_q == WdW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = StIdle;
                gnt_d   = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif

        // Outputs are registered from the next state so they align with it.
        trig_d = (state_d == StTrig);
        busy_d = (state_d != StIdle);
        ack_d  = (state_d == StRelease) ? gnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            ack_q       <= '0;
            ptr_q       <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FFT_SCHED_WATCHDOG_EN
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            ptr_q       <= ptr_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FFT_SCHED_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign trig      = trig_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_input_scheduler.sv
// Directed bench for fft_input_scheduler (NFFT=8, TIMEOUT=16). Inputs change
// 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_fft_input_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, done, wen;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic        streaming;
    logic [1:0]  gnt, ack;
    logic [3:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_wen, trig, busy, err;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int wen_seen = 0, trig_seen = 0, ack_seen = 0;
    int s_wen, s_trig, s_ack;

    always #5 clk = ~clk;

    fft_input_scheduler #(.NFFT(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .req_waddr (waddr),
        .req_wdata (wdata),
        .req_wen   (wen),
        .gnt       (gnt),
        .ack       (ack),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .trig      (trig),
        .streaming (streaming),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    always @(negedge clk) begin
        if (ram_wen === 1'b1) wen_seen++;
        if (trig === 1'b1) trig_seen++;
        if (ack !== 2'b00 && reset === 1'b0) ack_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  req, done, wen;
        logic [7:0]  waddr;
        logic [63:0] wdata;
        logic [1:0]  e_gnt;
        logic        e_busy, e_wen;
        logic [3:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] d, input logic [1:0] w,
                         input logic [7:0] a, input logic [63:0] dat);
        req = r; done = d; wen = w; waddr = a; wdata = dat;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;
    endtask

    // Entered in an IDLE cycle with req=11 driven; returns in the next IDLE cycle.
    task automatic frame(input logic [1:0] exp_gnt, input string name);
        settle();
        advance();
        done = exp_gnt; wen = exp_gnt;
        settle();
        chk({name, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        chk({name, "_wen"}, 64'(ram_wen), 64'd1);
        advance();
        done = 2'b00; wen = 2'b00;
        advance();
        streaming = 1'b1;
        advance();
        streaming = 1'b0;
        advance();
        settle();
        chk({name, "_ack"}, 64'(ack), 64'(exp_gnt));
        advance();
    endtask

    initial begin
        drive(2'b00, 2'b00, 2'b00, 8'h00, 64'h0);
        streaming = 1'b0;
        reset = 1'b1;
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{2'b01, 2'b00, 2'b11, 8'hF3, {32'hAAAA_0001, 32'h5555_0002},
                    2'b01, 1'b1, 1'b1, 4'h3, 32'h5555_0002};
        tbl[2]  = '{2'b00, 2'b00, 2'b01, 8'h05, {32'h0, 32'h77},
                    2'b01, 1'b1, 1'b1, 4'h5, 32'h77};
        tbl[3]  = '{2'b00, 2'b00, 2'b11, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[4]  = '{2'b11, 2'b00, 2'b00, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[5]  = '{2'b11, 2'b00, 2'b11, 8'h92, {32'hB1, 32'hA0},
                    2'b10, 1'b1, 1'b1, 4'h9, 32'hB1};
        tbl[6]  = '{2'b11, 2'b01, 2'b00, 8'h00, 64'h0, 2'b10, 1'b1, 1'b0, 4'h0, 32'h0};
        tbl[7]  = '{2'b01, 2'b00, 2'b00, 8'h00, 64'h0, 2'b10, 1'b1, 1'b0, 4'h0, 32'h0};
        tbl[8]  = '{2'b01, 2'b00, 2'b00, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[9]  = '{2'b00, 2'b00, 2'b00, 8'h00, 64'h0, 2'b01, 1'b1, 1'b0, 4'h0, 32'h0};
        tbl[10] = '{2'b00, 2'b00, 2'b00, 8'h00, 64'h0, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0};

        // Reset state
        do_reset();
        settle();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Single frame from requester 0; requester 1 writes throughout and is dropped.
        advance();
        s_wen = wen_seen; s_trig = trig_seen; s_ack = ack_seen;
        req = 2'b01;
        settle();
        chk("f1_idle_gnt", 64'(gnt), 64'd0);
        advance();
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, (i == 7) ? 2'b01 : 2'b00, 2'b11, {4'hF, 4'(i)},
                  {32'hDEAD_BEEF, 32'h10 + 32'(i)});
            settle();
            chk("f1_gnt", 64'(gnt), 64'd1);
            chk("f1_waddr", 64'(ram_waddr), 64'(i));
            chk("f1_wdata", 64'(ram_wdata), 64'h10 + 64'(i));
            advance();
        end
        drive(2'b01, 2'b00, 2'b10, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        settle();
        chk("f1_trig", 64'(trig), 64'd1);
        chk("f1_trig_wen", 64'(ram_wen), 64'd0);
        advance();
        wen = 2'b00;
        for (int j = 0; j < 8; j++) begin
            streaming = 1'b1;
            settle();
            chk("f1_stream_ack", 64'(ack), 64'd0);
            advance();
        end
        streaming = 1'b0;
        settle();
        chk("f1_wait_end_ack", 64'(ack), 64'd0);
        advance();
        req = 2'b00;
        settle();
        chk("f1_ack", 64'(ack), 64'd1);
        chk("f1_rel_gnt", 64'(gnt), 64'd1);
        advance();
        settle();
        chk("f1_after_ack", 64'(ack), 64'd0);
        chk("f1_after_gnt", 64'(gnt), 64'd0);
        chk("f1_after_busy", 64'(busy), 64'd0);
        chk("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("f1_wen_cycles", 64'(wen_seen - s_wen), 64'd8);
        chk("f1_trig_pulses", 64'(trig_seen - s_trig), 64'd1);
        chk("f1_ack_pulses", 64'(ack_seen - s_ack), 64'd1);

        // Four back-to-back frames with both requesting: grants alternate.
        do_reset();
        req = 2'b11;
        frame(2'b01, "rr0");
        frame(2'b10, "rr1");
        frame(2'b01, "rr2");
        frame(2'b10, "rr3");
        req = 2'b00;
        settle();
        chk("rr_frame_cnt", 64'(frame_cnt), 64'd4);
        advance();

        // Aborts in LOAD, foreign writes and foreign done.
        s_trig = trig_seen; s_ack = ack_seen;
        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].req, tbl[k].done, tbl[k].wen, tbl[k].waddr, tbl[k].wdata);
            settle();
            chk($sformatf("tbl%0d_gnt", k), 64'(gnt), 64'(tbl[k].e_gnt));
            chk($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].e_busy));
            chk($sformatf("tbl%0d_wen", k), 64'(ram_wen), 64'(tbl[k].e_wen));
            if (tbl[k].e_wen) begin
                chk($sformatf("tbl%0d_waddr", k), 64'(ram_waddr), 64'(tbl[k].e_waddr));
                chk($sformatf("tbl%0d_wdata", k), 64'(ram_wdata), 64'(tbl[k].e_wdata));
            end
            advance();
        end
        chk("abort_no_trig", 64'(trig_seen - s_trig), 64'd0);
        chk("abort_no_ack", 64'(ack_seen - s_ack), 64'd0);

        // Reset while in WAIT_END.
        s_trig = trig_seen; s_ack = ack_seen;
        req = 2'b10;
        advance();
        done = 2'b10;
        settle();
        chk("rw_gnt", 64'(gnt), 64'd2);
        advance();
        done = 2'b00;
        advance();
        streaming = 1'b1;
        advance();
        settle();
        chk("rw_busy", 64'(busy), 64'd1);
        chk("rw_frame_cnt_pre", 64'(frame_cnt), 64'd4);
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        streaming = 1'b0;
        req = 2'b00;
        settle();
        chk("rw_gnt_rst", 64'(gnt), 64'd0);
        chk("rw_ack_rst", 64'(ack), 64'd0);
        chk("rw_trig_rst", 64'(trig), 64'd0);
        chk("rw_busy_rst", 64'(busy), 64'd0);
        chk("rw_frame_cnt_rst", 64'(frame_cnt), 64'd0);
        chk("rw_err_rst", 64'(err), 64'd0);
        advance();
        advance();
        chk("rw_trig_pulses", 64'(trig_seen - s_trig), 64'd1);
        chk("rw_no_ack", 64'(ack_seen - s_ack), 64'd0);

        // Stream never starts.
        s_ack = ack_seen;
        req = 2'b01;
        advance();
        done = 2'b01;
        advance();
        done = 2'b00;
        advance();
        for (int k = 0; k < 16; k++) begin
            settle();
            chk("wd_busy_wait", 64'(busy), 64'd1);
            chk("wd_err_wait", 64'(err), 64'd0);
            advance();
        end
`ifdef FFT_SCHED_WATCHDOG_EN
        req = 2'b00;
        settle();
        chk("wd_err", 64'(err), 64'd1);
        chk("wd_busy", 64'(busy), 64'd0);
        chk("wd_gnt", 64'(gnt), 64'd0);
        chk("wd_no_ack", 64'(ack_seen - s_ack), 64'd0);
        advance();
        req = 2'b11;
        advance();
        settle();
        chk("wd_next_gnt", 64'(gnt), 64'd2);
        chk("wd_err_sticky", 64'(err), 64'd1);
        req = 2'b00;
        advance();
`else
        for (int k = 0; k < 20; k++) advance();
        settle();
        chk("nowd_busy", 64'(busy), 64'd1);
        chk("nowd_err", 64'(err), 64'd0);
        chk("nowd_no_ack", 64'(ack_seen - s_ack), 64'd0);
        advance();
        streaming = 1'b1;
        advance();
        streaming = 1'b0;
        advance();
        req = 2'b00;
        settle();
        chk("nowd_ack", 64'(ack), 64'd1);
        advance();
`endif
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
